pos_to_ascii_stream: RTL
========================

Name: pos_to_ascii_stream

Overview:
- Streaming decoder that converts 5-bit character positions back to 7-bit ASCII. It is the inverse of the team's ASCII-to-position encoder.
- Accepts one position per cycle over a valid/ready handshake. Decoded characters are buffered in a small FIFO and presented on a valid/ready output port.
- Sits between the position-domain datapath and any ASCII consumer (display or UART transmitter).
- Counts decoded characters and unassigned codes for debug.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 8, width of char_cnt and err_cnt

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_pos  input  5  character position code
in_valid  input  1  in_pos valid this cycle
in_ready  output  1  block can accept in_pos
out_ascii  output  7  decoded ASCII character at FIFO head
out_valid  output  1  out_ascii valid
out_ready  input  1  consumer accepts out_ascii
bad_code  output  1  one-cycle pulse: an unassigned code was accepted last cycle
char_cnt  output  CNT_W  characters accepted since reset, wraps modulo 2^CNT_W
err_cnt  output  CNT_W  unassigned codes accepted since reset, saturates at all-ones

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state clears immediately on rst_n low, independent of clk.
- Reset values: FIFO empty, out_valid=0, out_ascii=7'h00, in_ready=0 while rst_n low, bad_code=0, char_cnt=0, err_cnt=0.
- After reset release: in_ready=1 from the first clk edge after rst_n goes high.
- Decode map (combinational on in_pos, written into FIFO on accept):
  - 0 -> 7'h20 (space)
  - 1..26 -> 7'h60+pos ('a'..'z', 7'h61..7'h7A)
  - 27, 28 -> unassigned: write 7'h20, pulse bad_code, increment err_cnt
  - 29 -> 7'h2C (',')
  - 30 -> 7'h2E ('.')
  - 31 -> 7'h3F ('?')
- Accept (push) = in_valid & in_ready. in_ready = ~full; it depends only on registered FIFO occupancy, never combinationally on out_ready.
- Pop = out_valid & out_ready. out_valid = ~empty. out_ascii = FIFO head entry, registered; out_ascii is 7'h00 when empty.
- Latency: a character accepted at edge N is visible with out_valid=1 after edge N. There is no same-cycle input-to-output bypass.
- Full FIFO: in_ready=0. A simultaneous pop in that cycle frees one entry, and in_ready=1 after the edge.
- Simultaneous push and pop when neither empty nor full: occupancy unchanged, both pointers advance.
- Empty FIFO: a pop is impossible because out_valid=0. out_ready is ignored.
- Pointers: log2(DEPTH)+1 bits with a wrap bit. Full = address bits equal and wrap bits differ. Empty = pointers equal. Pointers wrap naturally modulo 2*DEPTH.
- Output holding: out_ascii and out_valid stay stable while out_valid=1 and out_ready=0, regardless of pushes.
- Counters:
  - char_cnt increments on every accept (assigned or unassigned code), wrapping from all-ones to 0.
  - err_cnt increments only on accept of 27 or 28 and holds at all-ones once saturated.
- bad_code is registered: high exactly in the cycle after an accepted unassigned code, otherwise 0.
- in_pos is ignored when in_valid=0 or in_ready=0. Counters and bad_code do not change.
- Reset mid-operation: buffered characters are discarded, and out_valid drops asynchronously with rst_n.

Test Plan:
1. Reset then full sweep: push in_pos 0..31 with out_ready=1 held. Required out_ascii sequence is 20, 61..7A, 20, 20, 2C, 2E, 3F; char_cnt=32, err_cnt=2, and bad_code pulses twice.
2. Backpressure: out_ready=0, push 'h','i','!'-free codes 8, 9, 0, 31, 5. After 4 accepts in_ready=0 and the 5th is held. Raise out_ready: outputs 68, 69, 20, 3F, then 65. in_ready returns to 1 one cycle after the first pop.
3. Full with simultaneous pop: at occupancy DEPTH, out_ready=1 and in_valid=1. Cycle 1 pops with no push; cycle 2 pushes and pops. Occupancy sequence is 4, 3, 3 and no data is lost or duplicated across 20 random transfers.
4. Output stability: hold out_ready=0 with head 7'h7A ('z', pos 26) while pushing two more. out_ascii stays 7A for 10 cycles.
5. Counter limits: accept 300 codes of pos 27. err_cnt=255 (saturated) and char_cnt=300 mod 256=44.
6. Async reset mid-stream: assert rst_n low between clk edges with 3 entries buffered. out_valid, in_ready, char_cnt and err_cnt go to 0 immediately. After release, the first push of pos 1 yields out_ascii=7'h61 one cycle later.

Source files
------------

// File: rtl/pos_to_ascii_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pos_to_ascii_stream                                           |
// | Purpose  : Decodes 5-bit character positions to 7-bit ASCII and buffers  |
// |            them in a small FIFO behind valid/ready handshakes. Keeps     |
// |            debug counts of decoded characters and unassigned codes.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pos_to_ascii_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       in_pos,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [6:0]       out_ascii,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             bad_code,
  output logic [CNT_W-1:0] char_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_ptr_w = c_aw + 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);

  // Storage and pointers (extra MSB is the wrap bit)
  logic [6:0]         mem_q [DEPTH];
  logic [6:0]         mem_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   char_cnt_q, char_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               bad_code_q, bad_code_d;
  // Held low through reset so in_ready only rises on the first edge after release
  logic               rdy_en_q, rdy_en_d;

  logic [6:0]     w_code;
  logic           w_unassigned;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [c_aw-1:0] w_wr_addr;
  logic [c_aw-1:0] w_rd_addr;

  assign w_wr_addr = wr_ptr_q[c_aw-1:0];
  assign w_rd_addr = rd_ptr_q[c_aw-1:0];
  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (w_wr_addr == w_rd_addr) && (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]);

  assign in_ready  = rdy_en_q & ~w_full;
  assign out_valid = ~w_empty;
  assign out_ascii = w_empty ? 7'h00 : mem_q[w_rd_addr];
  assign bad_code  = bad_code_q;
  assign char_cnt  = char_cnt_q;
  assign err_cnt   = err_cnt_q;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Position-to-ASCII decode; unassigned codes map to a space
  always_comb begin
    w_code       = 7'h20;
    w_unassigned = 1'b0;
    case (in_pos)
      5'd0:        w_code = 7'h20;
      5'd27, 5'd28: begin
        w_code       = 7'h20;
        w_unassigned = 1'b1;
      end
      5'd29:       w_code = 7'h2C;
      5'd30:       w_code = 7'h2E;
      5'd31:       w_code = 7'h3F;
      default:     w_code = 7'h60 + {2'b00, in_pos};
    endcase
  end

  // Next-state for FIFO, counters and the bad-code pulse
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    char_cnt_d = char_cnt_q;
    err_cnt_d  = err_cnt_q;
    bad_code_d = 1'b0;
    rdy_en_d   = 1'b1;
    if (w_push) begin
      mem_d[w_wr_addr] = w_code;
      wr_ptr_d         = wr_ptr_q + c_ptr_one;
      char_cnt_d       = char_cnt_q + c_cnt_one;
      bad_code_d       = w_unassigned;
      if (w_unassigned && !(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + c_cnt_one;
      end
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 7'h00;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      char_cnt_q <= '0;
      err_cnt_q  <= '0;
      bad_code_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      char_cnt_q <= char_cnt_d;
      err_cnt_q  <= err_cnt_d;
      bad_code_q <= bad_code_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

endmodule
`default_nettype wire
